// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding, oversampling
// constants and default FIFO geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned MID_SAMPLE   = 7;
  localparam int unsigned LAST_SAMPLE  = OVERSAMPLE - 1;
  localparam int unsigned SAMPLE_CNT_W = 4;

  localparam int unsigned UART_DATA_WIDTH_DEF        = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH_DEF     = 8;
  localparam int unsigned UART_RX_FIFO_PTR_WIDTH_DEF = 4;

endpackage

// File: rtl/uart_rx_buf.sv
// Receive FIFO: synchronous, show-ahead head word, pointers carry one extra
// wrap bit to distinguish full from empty.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = UART_RX_FIFO_DEPTH_DEF,
  parameter int unsigned PTR_WIDTH  = UART_RX_FIFO_PTR_WIDTH_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  wr_drop
);

  localparam int unsigned IDX_W = PTR_WIDTH - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  // Status flags and accept logic; a pop frees a slot for a same-cycle write.
  always_comb begin
    rd_valid = (wr_ptr != rd_ptr);
    full     = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
               (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    do_rd    = rd_en && rd_valid;
    do_wr    = wr_en && (!full || do_rd);
    wr_drop  = wr_en && !do_wr;
    rd_data  = rd_valid ? mem[rd_ptr[IDX_W-1:0]] : '0;
  end

  // Storage array; contents are only visible through a valid head pointer.
  always_ff @(posedge PCLK) begin
    if (do_wr) begin
      mem[wr_ptr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Read/write pointers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 7/8 data bits, optional parity, one stop
// bit, buffered in a small FIFO with sticky error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned UART_DATA_WIDTH        = UART_DATA_WIDTH_DEF,
  parameter int unsigned UART_RX_FIFO_DEPTH     = UART_RX_FIFO_DEPTH_DEF,
  parameter int unsigned UART_RX_FIFO_PTR_WIDTH = UART_RX_FIFO_PTR_WIDTH_DEF
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       rx_sample_pulse,
  input  logic                       UART_RX,
  input  logic                       data_bits,
  input  logic                       parity_en,
  input  logic                       parity_odd0_even1,
  input  logic                       rx_data_reg_rd,
  input  logic                       err_clr,
  output logic [UART_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_data_valid,
  output logic                       parity_err,
  output logic                       framing_err,
  output logic                       overflow_err
);

  localparam int unsigned W         = UART_DATA_WIDTH;
  localparam int unsigned BIT_CNT_W = $clog2(W);

  uart_state_e             state_q;
  uart_state_e             state_d;
  logic                    rx_meta_q;
  logic                    rx_sync_q;
  logic                    rx_prev_q;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [W-1:0]            shift_q;
  logic                    cfg_8bit_q;
  logic                    cfg_par_en_q;
  logic                    cfg_even_q;

  logic rx_fall;
  logic mid_hit;
  logic end_hit;
  logic last_bit;
  logic exp_par;
  logic shift_en;
  logic fifo_wr;
  logic fifo_drop;
  logic fifo_full;
  logic set_parity;
  logic set_framing;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Sampling strobes and frame-level decodes.
  always_comb begin
    rx_fall  = rx_prev_q && !rx_sync_q;
    mid_hit  = rx_sample_pulse && (sample_cnt_q == SAMPLE_CNT_W'(MID_SAMPLE));
    end_hit  = rx_sample_pulse && (sample_cnt_q == SAMPLE_CNT_W'(LAST_SAMPLE));
    last_bit = (bit_cnt_q == (cfg_8bit_q ? BIT_CNT_W'(W - 1) : BIT_CNT_W'(W - 2)));
    exp_par  = cfg_even_q ? ^shift_q : ~^shift_q;
  end

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and per-sample actions.
  always_comb begin
    state_d     = state_q;
    shift_en    = 1'b0;
    fifo_wr     = 1'b0;
    set_parity  = 1'b0;
    set_framing = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (mid_hit) state_d = rx_sync_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (end_hit) begin
          shift_en = 1'b1;
          if (last_bit) state_d = cfg_par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (end_hit) begin
          set_parity = (rx_sync_q != exp_par);
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (end_hit) begin
          fifo_wr     = rx_sync_q;
          set_framing = !rx_sync_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sample/bit counters, frame configuration latch and data shifter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      cfg_8bit_q   <= 1'b0;
      cfg_par_en_q <= 1'b0;
      cfg_even_q   <= 1'b0;
    end else begin
      if (state_d != state_q)  sample_cnt_q <= '0;
      else if (rx_sample_pulse) sample_cnt_q <= sample_cnt_q + 1'b1;

      if (state_q == ST_IDLE && rx_fall) begin
        cfg_8bit_q   <= data_bits;
        cfg_par_en_q <= parity_en;
        cfg_even_q   <= parity_odd0_even1;
        bit_cnt_q    <= '0;
      end

      if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        // Short frames take one extra shift on the last bit so the byte is
        // LSB-aligned with a zero in the top position.
        if (last_bit && !cfg_8bit_q) shift_q <= {1'b0, rx_sync_q, shift_q[W-1:2]};
        else                         shift_q <= {rx_sync_q, shift_q[W-1:1]};
      end
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      parity_err   <= 1'b0;
      framing_err  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      parity_err   <= set_parity  || (parity_err   && !err_clr);
      framing_err  <= set_framing || (framing_err  && !err_clr);
      overflow_err <= fifo_drop   || (overflow_err && !err_clr);
    end
  end

  uart_rx_buf #(
    .DATA_WIDTH (UART_DATA_WIDTH),
    .DEPTH      (UART_RX_FIFO_DEPTH),
    .PTR_WIDTH  (UART_RX_FIFO_PTR_WIDTH)
  ) u_buf (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .wr_en    (fifo_wr),
    .wr_data  (shift_q),
    .rd_en    (rx_data_reg_rd),
    .rd_data  (rx_data),
    .rd_valid (rx_data_valid),
    .full     (fifo_full),
    .wr_drop  (fifo_drop)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialised by the bench, expected
// bytes go through a scoreboard queue and are checked when popped.
module tb_uart_rx;

  localparam int STB_NONE = 0;
  localparam int STB_CLR  = 1;
  localparam int STB_RD   = 2;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       rx_sample_pulse;
  logic       UART_RX;
  logic       data_bits;
  logic       parity_en;
  logic       parity_odd0_even1;
  logic       rx_data_reg_rd;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overflow_err;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned div = 1;
  int unsigned phase = 0;
  logic        prev_valid = 1'b0;
  logic        par;
  logic [7:0]  exp_q [$];

  always #5 PCLK = ~PCLK;

  uart_rx #(
    .UART_DATA_WIDTH        (8),
    .UART_RX_FIFO_DEPTH     (8),
    .UART_RX_FIFO_PTR_WIDTH (4)
  ) dut (
    .PCLK              (PCLK),
    .PRESET            (PRESET),
    .rx_sample_pulse   (rx_sample_pulse),
    .UART_RX           (UART_RX),
    .data_bits         (data_bits),
    .parity_en         (parity_en),
    .parity_odd0_even1 (parity_odd0_even1),
    .rx_data_reg_rd    (rx_data_reg_rd),
    .err_clr           (err_clr),
    .rx_data           (rx_data),
    .rx_data_valid     (rx_data_valid),
    .parity_err        (parity_err),
    .framing_err       (framing_err),
    .overflow_err      (overflow_err)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_errs(input string tag, input logic pe, input logic fe, input logic oe);
    check1({tag, " parity_err"}, parity_err, pe);
    check1({tag, " framing_err"}, framing_err, fe);
    check1({tag, " overflow_err"}, overflow_err, oe);
  endtask

  // Reference parity from a population count.
  function automatic logic model_par(input logic [7:0] d, input logic even);
    int ones;
    ones = $countones(d);
    return even ? ones[0] : ~ones[0];
  endfunction

  // One PCLK cycle; inputs change and outputs are observed 1 time unit after the edge.
  task automatic step();
    rx_sample_pulse = (phase == 0);
    phase = (phase + 1 == div) ? 0 : phase + 1;
    @(posedge PCLK);
    #1;
    cyc++;
    if (!prev_valid && rx_data_valid) rise_cyc = cyc;
    prev_valid = rx_data_valid;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_head(input string tag);
    logic [7:0] e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed %02h expected <scoreboard entry>", tag, rx_data);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check8(tag, rx_data, e);
    end
  endtask

  task automatic read_byte(input string tag);
    check1({tag, " valid"}, rx_data_valid, 1'b1);
    expect_head(tag);
    rx_data_reg_rd = 1'b1;
    step();
    rx_data_reg_rd = 1'b0;
  endtask

  // Serialise one frame using the current config inputs. The config inputs are
  // inverted after the start bit to prove the DUT latched them. strobe fires
  // err_clr or a pop on the stop-bit sample cycle (div = 1 only); abort_bit
  // pulses PRESET mid-way through that bit index and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input logic par_bit,
                            input logic stop_bit, input int strobe, input int abort_bit);
    logic [10:0] bits;
    int          n;
    logic        eight;
    logic        pen;
    logic        sense;
    eight = data_bits;
    pen   = parity_en;
    sense = parity_odd0_even1;
    bits  = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < (eight ? 8 : 7); i++) begin
      bits[n] = data[i]; n++;
    end
    if (pen) begin
      bits[n] = par_bit; n++;
    end
    bits[n] = stop_bit; n++;
    for (int b = 0; b < n; b++) begin
      UART_RX = bits[b];
      if (b == 1) begin
        data_bits = ~eight;
        parity_en = ~pen;
        parity_odd0_even1 = ~sense;
      end
      for (int j = 0; j < 16 * int'(div); j++) begin
        if (b == abort_bit && j == 8 * int'(div)) begin
          PRESET  = 1'b1;
          UART_RX = 1'b1;
          steps(2);
          PRESET = 1'b0;
          data_bits = eight;
          parity_en = pen;
          parity_odd0_even1 = sense;
          return;
        end
        if (b == n - 1 && j == 10 && strobe == STB_CLR) err_clr = 1'b1;
        if (b == n - 1 && j == 10 && strobe == STB_RD) begin
          expect_head("pop on full write");
          rx_data_reg_rd = 1'b1;
        end
        step();
        err_clr = 1'b0;
        rx_data_reg_rd = 1'b0;
      end
    end
    data_bits = eight;
    parity_en = pen;
    parity_odd0_even1 = sense;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1;
    UART_RX = 1'b1;
    rx_sample_pulse = 1'b0;
    data_bits = 1'b1;
    parity_en = 1'b0;
    parity_odd0_even1 = 1'b0;
    rx_data_reg_rd = 1'b0;
    err_clr = 1'b0;
    steps(3);
    check1("reset valid", rx_data_valid, 1'b0);
    check8("reset rx_data", rx_data, 8'h00);
    check_errs("reset", 1'b0, 1'b0, 1'b0);
    PRESET = 1'b0;
    steps(20);

    // 8N1 0xA5: valid rises 155 cycles after the start edge is driven.
    start_cyc = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, STB_NONE, -1);
    exp_q.push_back(8'hA5);
    check32("A5 valid latency", rise_cyc, start_cyc + 155);
    check_errs("A5", 1'b0, 1'b0, 1'b0);
    read_byte("A5 data");
    check1("A5 empty after pop", rx_data_valid, 1'b0);
    rx_data_reg_rd = 1'b1;
    step();
    rx_data_reg_rd = 1'b0;
    check1("pop while empty", rx_data_valid, 1'b0);

    // 7E1 0x53: correct parity bit, then the same byte with it inverted.
    data_bits = 1'b0;
    parity_en = 1'b1;
    parity_odd0_even1 = 1'b1;
    par = model_par(8'h53 & 8'h7F, 1'b1);
    send_frame(8'h53, par, 1'b1, STB_NONE, -1);
    exp_q.push_back(8'h53);
    check_errs("7E1 good", 1'b0, 1'b0, 1'b0);
    read_byte("7E1 good data");
    send_frame(8'hD3, ~par, 1'b1, STB_NONE, -1);
    exp_q.push_back(8'h53);
    check_errs("7E1 bad", 1'b1, 1'b0, 1'b0);
    read_byte("7E1 bad data");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check1("parity_err cleared", parity_err, 1'b0);

    // 8O1 0xA5 with correct parity.
    data_bits = 1'b1;
    parity_odd0_even1 = 1'b0;
    par = model_par(8'hA5, 1'b0);
    send_frame(8'hA5, par, 1'b1, STB_NONE, -1);
    exp_q.push_back(8'hA5);
    check_errs("8O1", 1'b0, 1'b0, 1'b0);
    read_byte("8O1 data");

    // 8N1 0x3C with a low stop bit; err_clr on the same cycle must lose.
    parity_en = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, STB_CLR, -1);
    check1("framing set over clear", framing_err, 1'b1);
    check1("framing no write", rx_data_valid, 1'b0);
    steps(20);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    steps(200);
    check1("line held low no frame", framing_err, 1'b0);
    check1("line held low no write", rx_data_valid, 1'b0);
    UART_RX = 1'b1;
    steps(40);
    check1("after low hold no write", rx_data_valid, 1'b0);

    // Four-pulse low glitch on an idle line.
    UART_RX = 1'b0;
    steps(4);
    UART_RX = 1'b1;
    steps(40);
    check1("glitch no write", rx_data_valid, 1'b0);
    check_errs("glitch", 1'b0, 1'b0, 1'b0);

    // Nine bytes with no reads: ninth is dropped.
    for (int v = 1; v <= 9; v++) begin
      send_frame(8'(v), 1'b0, 1'b1, STB_NONE, -1);
      if (v <= 8) exp_q.push_back(8'(v));
    end
    check_errs("overflow", 1'b0, 1'b0, 1'b1);
    for (int v = 1; v <= 8; v++) read_byte("overflow drain");
    check1("drained empty", rx_data_valid, 1'b0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check1("overflow cleared", overflow_err, 1'b0);

    // Full FIFO with a pop on the write cycle: both take effect.
    for (int v = 8'h11; v <= 8'h18; v++) begin
      send_frame(8'(v), 1'b0, 1'b1, STB_NONE, -1);
      exp_q.push_back(8'(v));
    end
    send_frame(8'h19, 1'b0, 1'b1, STB_RD, -1);
    exp_q.push_back(8'h19);
    check1("pop+write on full no overflow", overflow_err, 1'b0);
    for (int v = 0; v < 8; v++) read_byte("pop+write drain");
    check1("pop+write empty", rx_data_valid, 1'b0);

    // Leave a byte and an error pending, then reset during data bit 4.
    parity_en = 1'b1;
    parity_odd0_even1 = 1'b1;
    par = model_par(8'h55, 1'b1);
    send_frame(8'h55, ~par, 1'b1, STB_NONE, -1);
    check1("pre-reset valid", rx_data_valid, 1'b1);
    check1("pre-reset parity_err", parity_err, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, STB_NONE, 5);
    exp_q.delete();
    check1("mid reset valid", rx_data_valid, 1'b0);
    check8("mid reset rx_data", rx_data, 8'h00);
    check_errs("mid reset", 1'b0, 1'b0, 1'b0);
    steps(60);
    check1("abandoned frame no write", rx_data_valid, 1'b0);

    // 8N1 0x7E after reset, sample pulse every other cycle.
    parity_en = 1'b0;
    div = 2;
    phase = 0;
    send_frame(8'h7E, 1'b0, 1'b1, STB_NONE, -1);
    exp_q.push_back(8'h7E);
    check_errs("7E", 1'b0, 1'b0, 1'b0);
    read_byte("7E data");
    check1("7E empty", rx_data_valid, 1'b0);
    div = 1;
    steps(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
